// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the scoreboard display. Produces the pixel
// coordinates consumed combinationally by the glyph blocks, together with
// the sync, active-video, line/frame strobes and the colon blink phase.
// Every output is a register. The qualifiers are computed from the next
// counter values, so they are valid in the same cycle as the coordinate
// they describe.
//
// Ports:
//   clk          pixel/system clock, rising-edge active
//   reset        synchronous, active-high; takes priority over pix_ce
//   pix_ce       pixel-rate enable; the raster advances only when high
//   pixel_x      current horizontal position, 0..H_TOTAL-1
//   pixel_y      current line, 0..V_TOTAL-1
//   video_on     high while (pixel_x, pixel_y) lies in the visible area
//   hsync        horizontal sync, asserted level given by HSYNC_POL
//   vsync        vertical sync, asserted level given by VSYNC_POL
//   line_start   one-cycle strobe on the first pixel of each new line
//   frame_start  one-cycle strobe on the first pixel of each new frame
//   blink        colon phase, toggles once every BLINK_FRAMES frames
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE     = 1024,
   parameter int unsigned H_FP         = 24,
   parameter int unsigned H_SYNC       = 136,
   parameter int unsigned H_BP         = 160,
   parameter int unsigned V_ACTIVE     = 768,
   parameter int unsigned V_FP         = 3,
   parameter int unsigned V_SYNC       = 6,
   parameter int unsigned V_BP         = 29,
   parameter logic        HSYNC_POL    = 1'b0,
   parameter logic        VSYNC_POL    = 1'b0,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_ce,
   output logic [10:0] pixel_x,
   output logic [9:0]  pixel_y,
   output logic        video_on,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start,
   output logic        blink
);

   // ------------------------------------------------------------------
   // Raster geometry, expressed at the counter widths so every compare
   // below is between equal-width unsigned operands.
   // ------------------------------------------------------------------
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_VIS_END  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

   // The blink counter needs at least one bit even when BLINK_FRAMES is 1;
   // in that case it stays at 0 and every frame toggles the phase.
   localparam int unsigned           BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

   // ------------------------------------------------------------------
   // Next-position and next-qualifier logic
   // ------------------------------------------------------------------
   logic [10:0]        x_next;
   logic [9:0]         y_next;
   logic               x_wrap;
   logic               y_wrap;
   logic               video_next;
   logic               hsync_next;
   logic               vsync_next;
   logic [BLINK_W-1:0] blink_cnt;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through it can leave a value unassigned and infer a latch.
   always_comb begin
      x_wrap = (pixel_x == H_LAST);
      y_wrap = (pixel_y == V_LAST);

      x_next = x_wrap ? 11'd0 : pixel_x + 11'd1;
      y_next = pixel_y;
      if (x_wrap) begin
         y_next = y_wrap ? 10'd0 : pixel_y + 10'd1;
      end

      // Qualifiers follow the coordinate they will be registered alongside.
      video_next = (x_next < H_VIS_END) && (y_next < V_VIS_END);
      hsync_next = ((x_next >= HS_START) && (x_next < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_next = ((y_next >= VS_START) && (y_next < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
   end

   // ------------------------------------------------------------------
   // Raster registers
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // A reset-induced return to (0,0) is not a wrap: no strobes.
         pixel_x     <= 11'd0;
         pixel_y     <= 10'd0;
         video_on    <= 1'b1;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         // Strobes last exactly one clk, even when pix_ce stays low after.
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pix_ce) begin
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            video_on    <= video_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            line_start  <= x_wrap;
            frame_start <= x_wrap && y_wrap;
         end
      end
   end

   // ------------------------------------------------------------------
   // Blink phase: counts frame_start strobes. The strobe is consumed on
   // the edge that ends it, so the new phase appears one cycle after the
   // frame_start that completes a half-period.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (frame_start) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Drives two instances from shared clk/reset/pix_ce: one with the default
// 1024x768 geometry and one with a tiny raster (12x7 total, BLINK_FRAMES=2)
// so whole frames and the blink sequence fit in a short run.
// A position-index model (linear pixel count modulo frame size, plus a
// count of frame strobes seen) predicts every output; a compare process
// checks both instances against it on every falling edge. Directed literal
// checks at hand-computed raster points pin the model itself.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic reset;
   logic pix_ce;
   logic chk_en = 1'b0;

   logic [10:0] px  [2];
   logic [9:0]  py  [2];
   logic        von [2];
   logic        hs  [2];
   logic        vs  [2];
   logic        ls  [2];
   logic        fs  [2];
   logic        bl  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_timing_gen u_dflt (
      .clk         (clk),
      .reset       (reset),
      .pix_ce      (pix_ce),
      .pixel_x     (px[0]),
      .pixel_y     (py[0]),
      .video_on    (von[0]),
      .hsync       (hs[0]),
      .vsync       (vs[0]),
      .line_start  (ls[0]),
      .frame_start (fs[0]),
      .blink       (bl[0])
   );

   vga_timing_gen #(
      .H_ACTIVE     (8),
      .H_FP         (1),
      .H_SYNC       (2),
      .H_BP         (1),
      .V_ACTIVE     (4),
      .V_FP         (1),
      .V_SYNC       (1),
      .V_BP         (1),
      .BLINK_FRAMES (2)
   ) u_small (
      .clk         (clk),
      .reset       (reset),
      .pix_ce      (pix_ce),
      .pixel_x     (px[1]),
      .pixel_y     (py[1]),
      .video_on    (von[1]),
      .hsync       (hs[1]),
      .vsync       (vs[1]),
      .line_start  (ls[1]),
      .frame_start (fs[1]),
      .blink       (bl[1])
   );

   // Geometry of each instance, as the model sees it.
   int m_ha  [2] = '{1024, 8};
   int m_hfp [2] = '{24, 1};
   int m_hsw [2] = '{136, 2};
   int m_ht  [2] = '{1344, 12};
   int m_va  [2] = '{768, 4};
   int m_vfp [2] = '{3, 1};
   int m_vsw [2] = '{6, 1};
   int m_vt  [2] = '{806, 7};
   int m_bf  [2] = '{30, 2};

   // Model state: linear pixel index within the frame, number of frame
   // strobes already seen, and the strobe flags for the current cycle.
   int m_p  [2];
   int m_n  [2];
   bit m_ls [2];
   bit m_fs [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_p[i]  <= 0;
            m_n[i]  <= 0;
            m_ls[i] <= 1'b0;
            m_fs[i] <= 1'b0;
         end else begin
            if (m_fs[i]) m_n[i] <= m_n[i] + 1;
            if (pix_ce) begin
               m_p[i]  <= (m_p[i] + 1) % (m_ht[i] * m_vt[i]);
               m_ls[i] <= ((m_p[i] + 1) % m_ht[i]) == 0;
               m_fs[i] <= ((m_p[i] + 1) % (m_ht[i] * m_vt[i])) == 0;
            end else begin
               m_ls[i] <= 1'b0;
               m_fs[i] <= 1'b0;
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            int x;
            int y;
            int hs_lo;
            int vs_lo;
            x     = m_p[i] % m_ht[i];
            y     = m_p[i] / m_ht[i];
            hs_lo = m_ha[i] + m_hfp[i];
            vs_lo = m_va[i] + m_vfp[i];
            check($sformatf("cmp%0d_pixel_x", i), px[i], x);
            check($sformatf("cmp%0d_pixel_y", i), py[i], y);
            check($sformatf("cmp%0d_video_on", i), von[i], (x < m_ha[i]) && (y < m_va[i]));
            check($sformatf("cmp%0d_hsync", i), hs[i], !((x >= hs_lo) && (x < hs_lo + m_hsw[i])));
            check($sformatf("cmp%0d_vsync", i), vs[i], !((y >= vs_lo) && (y < vs_lo + m_vsw[i])));
            check($sformatf("cmp%0d_line_start", i), ls[i], m_ls[i]);
            check($sformatf("cmp%0d_frame_start", i), fs[i], m_fs[i]);
            check($sformatf("cmp%0d_blink", i), bl[i], (m_n[i] / m_bf[i]) % 2);
         end
      end
   end

   // Hand-computed expectations at a specific raster point.
   task automatic pin(input int i, input string tag, input int x, input int y, input int v,
                      input int h, input int vv, input int l, input int f, input int b);
      check({tag, "_x"},     px[i],  x);
      check({tag, "_y"},     py[i],  y);
      check({tag, "_video"}, von[i], v);
      check({tag, "_hsync"}, hs[i],  h);
      check({tag, "_vsync"}, vs[i],  vv);
      check({tag, "_line"},  ls[i],  l);
      check({tag, "_frame"}, fs[i],  f);
      check({tag, "_blink"}, bl[i],  b);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   int kk;
   int bl_tab [6] = '{0, 0, 1, 1, 0, 0};

   task automatic run_to(input int target);
      repeat (target - kk) @(negedge clk);
      kk = target;
   endtask

   initial begin
      reset  = 1'b1;
      pix_ce = 1'b0;
      step(3);
      chk_en = 1'b1;
      pin(0, "rst_d", 0, 0, 1, 1, 1, 0, 0, 0);
      pin(1, "rst_s", 0, 0, 1, 1, 1, 0, 0, 0);

      // Default geometry: first line, visible edge and hsync window.
      reset  = 1'b0;
      pix_ce = 1'b1;
      step(1023); pin(0, "d_x1023", 1023, 0, 1, 1, 1, 0, 0, 0);
      step(1);    pin(0, "d_x1024", 1024, 0, 0, 1, 1, 0, 0, 0);
      step(23);   pin(0, "d_x1047", 1047, 0, 0, 1, 1, 0, 0, 0);
      step(1);    pin(0, "d_x1048", 1048, 0, 0, 0, 1, 0, 0, 0);
      step(135);  pin(0, "d_x1183", 1183, 0, 0, 0, 1, 0, 0, 0);
      step(1);    pin(0, "d_x1184", 1184, 0, 0, 1, 1, 0, 0, 0);
      step(159);  pin(0, "d_x1343", 1343, 0, 0, 1, 1, 0, 0, 0);

      // pix_ce 1,0,0,1 across the line wrap.
      step(1);    pin(0, "d_wrap",  0, 1, 1, 1, 1, 1, 0, 0);
      pix_ce = 1'b0;
      step(1);    pin(0, "d_hold1", 0, 1, 1, 1, 1, 0, 0, 0);
      step(1);    pin(0, "d_hold2", 0, 1, 1, 1, 1, 0, 0, 0);
      pix_ce = 1'b1;
      step(1);    pin(0, "d_resume", 1, 1, 1, 1, 1, 0, 0, 0);
      step(1342); pin(0, "d_y1end", 1343, 1, 0, 1, 1, 0, 0, 0);
      step(1);    pin(0, "d_y2", 0, 2, 1, 1, 1, 1, 0, 0);
      step(500);  pin(0, "d_x500", 500, 2, 1, 1, 1, 0, 0, 0);

      // Mid-line reset with pix_ce still high: reset wins, no strobe.
      reset = 1'b1;
      step(1);
      pin(0, "d_midrst", 0, 0, 1, 1, 1, 0, 0, 0);
      pin(1, "s_rst2",   0, 0, 1, 1, 1, 0, 0, 0);
      reset = 1'b0;
      kk    = 0;

      // Small geometry: syncs, full frames and the blink sequence.
      run_to(8);  pin(1, "s_x8",   8, 0, 0, 1, 1, 0, 0, 0);
      run_to(9);  pin(1, "s_x9",   9, 0, 0, 0, 1, 0, 0, 0);
      run_to(10); pin(1, "s_x10", 10, 0, 0, 0, 1, 0, 0, 0);
      run_to(11); pin(1, "s_x11", 11, 0, 0, 1, 1, 0, 0, 0);
      run_to(12); pin(1, "s_y1",   0, 1, 1, 1, 1, 1, 0, 0);
      run_to(59); pin(1, "s_y4e", 11, 4, 0, 1, 1, 0, 0, 0);
      run_to(60); pin(1, "s_y5",   0, 5, 0, 1, 0, 1, 0, 0);
      run_to(69); pin(1, "s_y5x9", 9, 5, 0, 0, 0, 0, 0, 0);
      run_to(71); pin(1, "s_y5e", 11, 5, 0, 1, 0, 0, 0, 0);
      run_to(72); pin(1, "s_y6",   0, 6, 0, 1, 1, 1, 0, 0);
      for (int f = 1; f <= 6; f++) begin
         run_to(84 * f);
         pin(1, $sformatf("s_frame%0d", f), 0, 0, 1, 1, 1, 1, 1, bl_tab[f-1]);
         if (f == 1) begin
            run_to(85);
            pin(1, "s_after_fs", 1, 0, 1, 1, 1, 0, 0, 0);
         end
      end

      // Mid-frame reset while blink is high: everything returns to rest.
      run_to(504 + 41); pin(1, "s_x5y3", 5, 3, 1, 1, 1, 0, 0, 1);
      reset = 1'b1;
      step(1);
      pin(1, "s_midrst", 0, 0, 1, 1, 1, 0, 0, 0);
      pin(0, "d_rst3",   0, 0, 1, 1, 1, 0, 0, 0);
      reset = 1'b0;
      step(20);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster scan that all scoreboard glyph blocks (digits, colon, labels) consume.
- Produces pixel_x/pixel_y coordinates, horizontal/vertical sync, an active-video qualifier, and line/frame strobes.
- Provides a frame-counted blink phase for the clock colon.
- Sits between the pixel clock and the glyph/colour mux; glyph blocks decode pixel_x/pixel_y combinationally in the same cycle.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels); H_TOTAL = sum = 1344
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 806
- HSYNC_POL, 1'b0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 1'b0, asserted level of vsync
- BLINK_FRAMES, 30, frames per blink half-period

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pix_ce  input  1  pixel-rate enable; counters advance only when high
- pixel_x  output  11  current horizontal position, 0..H_TOTAL-1
- pixel_y  output  10  current line, 0..V_TOTAL-1
- video_on  output  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- hsync  output  1  horizontal sync, polarity per HSYNC_POL
- vsync  output  1  vertical sync, polarity per VSYNC_POL
- line_start  output  1  one-cycle strobe when pixel_x wraps to 0
- frame_start  output  1  one-cycle strobe when pixel_x and pixel_y both wrap to 0
- blink  output  1  colon blink phase, toggles every BLINK_FRAMES frames

Behaviour:
- Clock, reset and state:
  - Single clock domain; every output is a register, updated on rising clk.
  - reset dominates pix_ce. On reset: pixel_x=0, pixel_y=0, video_on=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0, blink=0, blink frame counter=0.
  - Reset asserted mid-line or mid-frame returns to (0,0) on the next edge. No strobe is emitted for a reset-induced return.
- Counter advance (pix_ce=1):
  - pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments.
  - pixel_y at V_TOTAL-1 wraps to 0 when pixel_x wraps.
  - All arithmetic is unsigned. Counters never exceed TOTAL-1.
- pix_ce=0: all outputs hold, except line_start and frame_start, which deassert (strobes are exactly one clk cycle).
- Derived outputs, computed from the next counter values so they stay coincident with pixel_x/pixel_y. There is zero latency between a coordinate and its qualifiers.
  - video_on = (x < H_ACTIVE) && (y < V_ACTIVE).
  - hsync asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking.
  - vsync asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Strobes:
  - line_start = 1 for the cycle in which the new pixel_x is 0 following a wrap.
  - frame_start = 1 for the cycle in which the new (x,y) is (0,0) following a wrap. line_start is also 1 in that cycle.
- Blink:
  - The frame counter increments on each frame_start event.
  - When the count reaches BLINK_FRAMES-1 and another frame_start occurs, the counter clears and blink toggles.
  - BLINK_FRAMES=1 toggles blink every frame.
- Glyph consumers sample pixel_x/pixel_y only when video_on=1. Coordinates during blanking are still valid counter values.

Test Plan:
- Reset release, pix_ce=1 continuously, default params -> pixel_x counts 0..1343, then 0 with pixel_y=1. line_start pulses exactly at each x=0 after a wrap. video_on drops at x=1024.
- Sweep one line, checking hsync -> hsync=0 exactly for x=1048..1183, 1 elsewhere. Same on line y=780 (vertical blanking).
- Run a full frame -> vsync=0 exactly for y=771..776. After (1343,805) the next cycle is (0,0) with frame_start=1 and line_start=1.
- Toggle pix_ce 1,0,0,1 around x=1343 -> counters hold while pix_ce=0. line_start is high for one clk only, then low while held.
- Small params (H 8/1/2/1, V 4/1/1/1, BLINK_FRAMES=2), run 6 frames -> blink 0,0,1,1,0,0 at successive frame_starts.
- Assert reset at (500,300) for one cycle -> next cycle is (0,0) with frame_start=0, blink=0, syncs deasserted, video_on=1.
